key_event_classifier: RTL and testbench
=======================================

# key_event_classifier

Classifies debounced key activity into single-press, double-press, long-press and auto-repeat events. Sits directly downstream of `key_debounce` and consumes its `key_value`/`key_flag` pair. Emits one-cycle event pulses for `beep_control` and other feedback or UI consumers. All timing comes from cycle-count parameters, so the block needs no knowledge of clock frequency.

## Interface
Parameters:
- `LONG_CNT`, 50_000_000, hold duration in cycles that qualifies a long press (1 s at 50 MHz); must be ≥ 2
- `DBL_GAP`, 15_000_000, maximum cycles after the first release within which a second press counts as a double press; must be ≥ 2
- `REPEAT_CNT`, 10_000_000, auto-repeat period in cycles while a long press is held; must be ≥ 2

Ports:
- `sys_clk`  in  1  system clock; all logic on rising edge
- `sys_rst_n`  in  1  reset, asynchronous and active-low
- `key_value`  in  1  debounced key level: 0 = pressed, 1 = released
- `key_flag`  in  1  one-cycle pulse, valid when `key_value` has just changed
- `short_press`  out  1  one-cycle pulse: single press confirmed
- `double_press`  out  1  one-cycle pulse: double press confirmed
- `long_press`  out  1  one-cycle pulse: hold reached `LONG_CNT`
- `repeat_pulse`  out  1  one-cycle pulse every `REPEAT_CNT` cycles while the long hold continues
- `key_held`  out  1  level: high in PRESS1, PRESS2 and LONG

## Operation
- Event definitions:
  - Press event: `key_flag`=1 and `key_value`=0.
  - Release event: `key_flag`=1 and `key_value`=1.
  - `key_flag`=0 means no event; `key_value` is ignored.
- A press event in a pressed state, or a release event in IDLE/WAIT2, is ignored with no state change. This covers recovery from reset while the key is held.
- There is one shared counter `cnt`, sized with `$clog2` of the largest parameter. It clears to 0 on every state entry, increments each cycle while in a timed state, and never wraps because every threshold forces a transition or a clear.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG.
  - IDLE: on a press event, go to PRESS1.
  - PRESS1: on a release event, go to WAIT2. Else if `cnt`==`LONG_CNT`-1, go to LONG and pulse `long_press`.
  - WAIT2: on a press event, go to PRESS2. Else if `cnt`==`DBL_GAP`-1, go to IDLE and pulse `short_press`.
  - PRESS2: on a release event, go to IDLE and pulse `double_press`. Hold length in PRESS2 is not timed (no long detection).
  - LONG: on a release event, go to IDLE with no pulse. Else if `cnt`==`REPEAT_CNT`-1, pulse `repeat_pulse` and clear `cnt`.
- Simultaneous events: a key event always takes priority over a timeout in the same cycle.
  - PRESS1 release at `cnt`==`LONG_CNT`-1: goes to WAIT2, no `long_press`.
  - WAIT2 press at timeout: goes to PRESS2, no `short_press`.
  - LONG release at repeat terminal count: no `repeat_pulse`.
- Event outputs are mutually exclusive; at most one is high in any cycle.
- Reset mid-operation forces IDLE and `cnt`=0. Any pending single-press decision is discarded with no pulse.

## Timing
- All outputs are registered. Reset value of `short_press`, `double_press`, `long_press`, `repeat_pulse` and `key_held` is 0.
- Cycle numbering: cycle N is the cycle in which the relevant `key_flag` is high.
- Press in IDLE at N: `key_held`=1 from N+1.
- Long press: `long_press` high in N+`LONG_CNT`+1. `repeat_pulse` first high in N+`LONG_CNT`+`REPEAT_CNT`+1, then every `REPEAT_CNT` cycles.
- Release at M in PRESS1: `key_held`=0 from M+1. With no second press, `short_press` is high in M+`DBL_GAP`+1.
- Release at M in PRESS2: `double_press` high in M+1; `key_held`=0 from M+1.
- Release at M in LONG: `key_held`=0 from M+1; no pulse from M+1 onward.
- Consecutive `key_flag` pulses may arrive on adjacent cycles; each one is processed.

## Test plan
Bench parameters: `LONG_CNT`=20, `DBL_GAP`=10, `REPEAT_CNT`=5.
- Press at cycle 10, release at 15 -> `short_press` exactly one cycle at 26; no other pulses; `key_held` high cycles 11–15.
- Press at 10, release at 13, press at 18, release at 25 -> `double_press` at 26 only; no `short_press`.
- Press at 10, hold to release at 47 -> `long_press` at 31; `repeat_pulse` at 36, 41, 46; nothing after release; `key_held` low from 48.
- Boundaries:
  - Press at 10, release at 30 (cnt==19) -> no `long_press`; `short_press` at 41.
  - Press at 10, release at 12, press at 22 (WAIT2 timeout cycle) -> PRESS2; release at 24 -> `double_press` at 25; no `short_press`.
- Reset asserted at 20 during WAIT2 (press 10, release 12) with `key_value` held low through reset -> all outputs 0; no `short_press`. A release flag after reset is ignored, and the next press/release at 40/42 yields `short_press` at 53.

Source files
------------

// File: rtl/key_event_classifier.sv
// Turns debounced key_value/key_flag activity into single, double, long and
// auto-repeat event pulses, with all timing expressed as cycle counts.
module key_event_classifier #(
    parameter int LONG_CNT   = 50_000_000,
    parameter int DBL_GAP    = 15_000_000,
    parameter int REPEAT_CNT = 10_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_value,
    input  logic key_flag,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic key_held
);

    localparam int MAX_CNT = (LONG_CNT > DBL_GAP) ?
                             ((LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT) :
                             ((DBL_GAP > REPEAT_CNT) ? DBL_GAP : REPEAT_CNT);
    localparam int CW = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] DBL_TC  = CW'(DBL_GAP - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CNT - 1);

    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          short_nxt, double_nxt, long_nxt, repeat_nxt, held_nxt;
    logic          press_ev, release_ev;

    assign press_ev   = key_flag & ~key_value;
    assign release_ev = key_flag &  key_value;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        // Key events are tested before terminal counts so they always win a tie.
        case (state)
            IDLE: begin
                if (press_ev) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (release_ev) begin
                    state_nxt = WAIT2;
                end else if (cnt == LONG_TC) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT2: begin
                if (press_ev) begin
                    state_nxt = PRESS2;
                end else if (cnt == DBL_TC) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRESS2: begin
                if (release_ev) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end
            end
            LONG: begin
                if (release_ev) begin
                    state_nxt = IDLE;
                end else if (cnt == REP_TC) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Every state entry starts timing from zero.
        if (state_nxt != state) cnt_nxt = '0;
        held_nxt = (state_nxt == PRESS1) || (state_nxt == PRESS2) || (state_nxt == LONG);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            short_press  <= short_nxt;
            double_press <= double_nxt;
            long_press   <= long_nxt;
            repeat_pulse <= repeat_nxt;
            key_held     <= held_nxt;
        end
    end

endmodule

// File: tb/tb_key_event_classifier.sv
// Directed bench for key_event_classifier: timestamp-based reference model
// compared every cycle, plus literal pulse-cycle expectations per scenario.
module tb_key_event_classifier;

    localparam int LONG_CNT   = 20;
    localparam int DBL_GAP    = 10;
    localparam int REPEAT_CNT = 5;

    localparam int M_IDLE = 0, M_HELD1 = 1, M_GAP = 2, M_HELD2 = 3, M_LONG = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_value = 1'b1;
    logic key_flag  = 1'b0;
    logic short_press, double_press, long_press, repeat_pulse, key_held;

    key_event_classifier #(
        .LONG_CNT  (LONG_CNT),
        .DBL_GAP   (DBL_GAP),
        .REPEAT_CNT(REPEAT_CNT)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_value   (key_value),
        .key_flag    (key_flag),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .key_held    (key_held)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc    = 0;
    int t_base = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int mode   = M_IDLE;
    int t0     = 0;
    logic [4:0] exp_cur = '0;  // {short, double, long, repeat, held}
    int q_short[$], q_dbl[$], q_long[$], q_rep[$];
    string names[5] = '{"short_press", "double_press", "long_press", "repeat_pulse", "key_held"};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, act, exp, cyc - t_base);
        end
    endtask

    // Compare this cycle's outputs, then advance the model on this cycle's inputs.
    task automatic check_cycle();
        logic [4:0] act, e;
        logic p, r;
        logic es, ed, el, er;
        act = {short_press, double_press, long_press, repeat_pulse, key_held};
        e   = sys_rst_n ? exp_cur : 5'b0;
        for (int i = 0; i < 5; i++) chk(names[i], int'(act[4-i]), int'(e[4-i]));
        if (short_press)  q_short.push_back(cyc - t_base);
        if (double_press) q_dbl.push_back(cyc - t_base);
        if (long_press)   q_long.push_back(cyc - t_base);
        if (repeat_pulse) q_rep.push_back(cyc - t_base);
        if (!sys_rst_n) begin
            mode    = M_IDLE;
            exp_cur = '0;
            return;
        end
        p  = key_flag && !key_value;
        r  = key_flag && key_value;
        es = 1'b0; ed = 1'b0; el = 1'b0; er = 1'b0;
        case (mode)
            M_IDLE:  if (p) begin mode = M_HELD1; t0 = cyc; end
            M_HELD1: if (r) begin mode = M_GAP; t0 = cyc; end
                     else if (cyc - t0 == LONG_CNT) begin mode = M_LONG; t0 = cyc; el = 1'b1; end
            M_GAP:   if (p) mode = M_HELD2;
                     else if (cyc - t0 == DBL_GAP) begin mode = M_IDLE; es = 1'b1; end
            M_HELD2: if (r) begin mode = M_IDLE; ed = 1'b1; end
            M_LONG:  if (r) mode = M_IDLE;
                     else if (cyc != t0 && (cyc - t0) % REPEAT_CNT == 0) er = 1'b1;
            default: mode = M_IDLE;
        endcase
        exp_cur = {es, ed, el, er, (mode == M_HELD1 || mode == M_HELD2 || mode == M_LONG)};
    endtask

    task automatic tick();
        @(negedge sys_clk);
        check_cycle();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc - t_base < n) tick();
    endtask

    task automatic flag_at(input int n, input logic v);
        run_to(n);
        key_value = v;
        key_flag  = 1'b1;
        tick();
        key_flag  = 1'b0;
    endtask

    task automatic start_scn();
        sys_rst_n = 1'b0;
        key_value = 1'b1;
        key_flag  = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        t_base    = cyc;
        q_short.delete(); q_dbl.delete(); q_long.delete(); q_rep.delete();
    endtask

    task automatic expect_one(input string name, input int sz, input int at, input int exp_at);
        chk({name, "_count"}, sz, 1);
        if (sz > 0) chk({name, "_cycle"}, at, exp_at);
    endtask

    initial begin
        // Reset state: outputs must be zero while reset is held.
        start_scn();
        chk("reset_key_held", int'(key_held), 0);
        chk("reset_pulses", int'({short_press, double_press, long_press, repeat_pulse}), 0);

        // Single press.
        start_scn();
        flag_at(10, 1'b0); flag_at(15, 1'b1); run_to(40);
        expect_one("s1_short", q_short.size(), q_short.size() ? q_short[0] : -1, 26);
        chk("s1_other_pulses", q_dbl.size() + q_long.size() + q_rep.size(), 0);

        // Double press.
        start_scn();
        flag_at(10, 1'b0); flag_at(13, 1'b1); flag_at(18, 1'b0); flag_at(25, 1'b1); run_to(45);
        expect_one("s2_double", q_dbl.size(), q_dbl.size() ? q_dbl[0] : -1, 26);
        chk("s2_short_count", q_short.size(), 0);

        // Long press with auto-repeat.
        start_scn();
        flag_at(10, 1'b0); flag_at(47, 1'b1); run_to(65);
        expect_one("s3_long", q_long.size(), q_long.size() ? q_long[0] : -1, 31);
        chk("s3_repeat_count", q_rep.size(), 3);
        for (int i = 0; i < q_rep.size() && i < 3; i++) chk("s3_repeat_cycle", q_rep[i], 36 + 5 * i);
        chk("s3_short_double", q_short.size() + q_dbl.size(), 0);

        // Release exactly at the long terminal count.
        start_scn();
        flag_at(10, 1'b0); flag_at(30, 1'b1); run_to(55);
        chk("s4_long_count", q_long.size(), 0);
        expect_one("s4_short", q_short.size(), q_short.size() ? q_short[0] : -1, 41);

        // Second press on the double-press timeout cycle.
        start_scn();
        flag_at(10, 1'b0); flag_at(12, 1'b1); flag_at(22, 1'b0); flag_at(24, 1'b1); run_to(45);
        expect_one("s5_double", q_dbl.size(), q_dbl.size() ? q_dbl[0] : -1, 25);
        chk("s5_short_count", q_short.size(), 0);

        // Reset during the double-press window with the key held.
        start_scn();
        flag_at(10, 1'b0); flag_at(12, 1'b1); run_to(20);
        sys_rst_n = 1'b0;
        key_value = 1'b0;
        tick();
        chk("s6_reset_held", int'(key_held), 0);
        run_to(25);
        sys_rst_n = 1'b1;
        flag_at(30, 1'b1);
        run_to(39);
        chk("s6_short_before", q_short.size(), 0);
        flag_at(40, 1'b0); flag_at(42, 1'b1); run_to(65);
        expect_one("s6_short", q_short.size(), q_short.size() ? q_short[0] : -1, 53);
        chk("s6_other_pulses", q_dbl.size() + q_long.size() + q_rep.size(), 0);

        // Adjacent flags: press then release on consecutive cycles.
        start_scn();
        flag_at(10, 1'b0); flag_at(11, 1'b1); run_to(30);
        expect_one("s7_short", q_short.size(), q_short.size() ? q_short[0] : -1, 22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
